sr_cmd_gen: RTL and testbench

- Upstream command stage for the sr_ff flip-flop.
- Converts two raw, asynchronous push-button requests (set, reset) into clean, registered s/r pulses that drive sr_ff directly.
- Guarantees s and r are never high together, so sr_ff never sees the forbidden s=1,r=1 input.
- Provides input synchronisation, debounce, edge detection, fixed-width pulse generation, minimum spacing and request queuing.

---
 rtl/sr_cmd_gen_pkg.sv | 21 ++
 rtl/sr_cmd_gen_btn_debounce.sv | 50 +++++
 rtl/sr_cmd_gen.sv | 131 +++++++++++++
 tb/tb_sr_cmd_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sr_cmd_gen_pkg.sv
// Shared definitions for the sr_ff command generator: FSM encoding,
// default timing values and a counter-width helper.
package sr_cmd_gen_pkg;

  localparam int DB_CYCLES_DEF    = 4;
  localparam int PULSE_CYCLES_DEF = 2;
  localparam int GAP_CYCLES_DEF   = 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SET_PULSE = 2'd1,
    RST_PULSE = 2'd2,
    GAP       = 2'd3
  } state_t;

  // Bits needed to hold 0..max_val, never fewer than one.
  function automatic int cnt_width(input int max_val);
    cnt_width = (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sr_cmd_gen_btn_debounce.sv
// Per-button front end: 2-flop synchroniser, stable-count debounce and
// rising-edge detect on the debounced level.
module btn_debounce
  import sr_cmd_gen_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic level,
  output logic rise
);

  localparam int CW = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic          sync_q1;
  logic          sync;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Any disagreement that does not persist for DB_CYCLES edges restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync    <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_q1 <= btn_in;
      sync    <= sync_q1;
      level_d <= level;
      if (sync != level) begin
        if (cnt == DB_LAST) begin
          level <= sync;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/sr_cmd_gen.sv
// Turns two bouncy push-buttons into clean, mutually exclusive s/r pulses
// for sr_ff, queuing requests that arrive while a pulse is in progress.
module sr_cmd_gen
  import sr_cmd_gen_pkg::*;
#(
  parameter int DB_CYCLES    = DB_CYCLES_DEF,
  parameter int PULSE_CYCLES = PULSE_CYCLES_DEF,
  parameter int GAP_CYCLES   = GAP_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic rst_btn,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
);

  localparam int PMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int PW   = cnt_width(PMAX);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [PW-1:0] GAP_LAST   = PW'(GAP_CYCLES - 1);

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] pcnt;
  logic [PW-1:0] pcnt_next;
  logic          pend_s;
  logic          pend_s_next;
  logic          pend_r;
  logic          pend_r_next;
  logic          conflict_next;
  logic          rise_s;
  logic          rise_r;
  logic          level_s;
  logic          level_r;
  logic          set_req;
  logic          rst_req;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_in (set_btn),
    .level  (level_s),
    .rise   (rise_s)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_rst (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_in (rst_btn),
    .level  (level_r),
    .rise   (rise_r)
  );

  assign set_req = rise_s | pend_s;
  assign rst_req = rise_r | pend_r;

  // s/r are decoded from the next state so they are registered yet aligned with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pcnt     <= '0;
      pend_s   <= 1'b0;
      pend_r   <= 1'b0;
      s        <= 1'b0;
      r        <= 1'b0;
      conflict <= 1'b0;
    end else begin
      state    <= state_next;
      pcnt     <= pcnt_next;
      pend_s   <= pend_s_next;
      pend_r   <= pend_r_next;
      s        <= (state_next == SET_PULSE);
      r        <= (state_next == RST_PULSE);
      conflict <= conflict_next;
    end
  end

  always_comb begin
    state_next    = state;
    pcnt_next     = pcnt;
    pend_s_next   = pend_s;
    pend_r_next   = pend_r;
    conflict_next = 1'b0;
    case (state)
      IDLE: begin
        if (set_req && rst_req) begin
          pend_s_next   = 1'b0;
          pend_r_next   = 1'b0;
          conflict_next = 1'b1;
        end else if (set_req) begin
          state_next  = SET_PULSE;
          pend_s_next = 1'b0;
          pcnt_next   = '0;
        end else if (rst_req) begin
          state_next  = RST_PULSE;
          pend_r_next = 1'b0;
          pcnt_next   = '0;
        end
      end
      SET_PULSE, RST_PULSE: begin
        pend_s_next = pend_s | rise_s;
        pend_r_next = pend_r | rise_r;
        if (pcnt == PULSE_LAST) begin
          state_next = GAP;
          pcnt_next  = '0;
        end else begin
          pcnt_next = pcnt + PW'(1);
        end
      end
      GAP: begin
        pend_s_next = pend_s | rise_s;
        pend_r_next = pend_r | rise_r;
        if (pcnt == GAP_LAST) begin
          state_next = IDLE;
          pcnt_next  = '0;
        end else begin
          pcnt_next = pcnt + PW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed bench for sr_cmd_gen with default timing (DB=4, PULSE=2, GAP=1);
// edge counts below are relative to the first edge that samples a button change.
module tb_sr_cmd_gen;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic set_btn = 1'b0;
  logic rst_btn = 1'b0;
  logic s;
  logic r;
  logic busy;
  logic conflict;

  int   pass_cnt     = 0;
  int   total_cnt    = 0;
  int   s_cycles     = 0;
  logic ff_q         = 1'b0;
  logic overlap_seen = 1'b0;

  sr_cmd_gen #(
    .DB_CYCLES    (4),
    .PULSE_CYCLES (2),
    .GAP_CYCLES   (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_btn  (set_btn),
    .rst_btn  (rst_btn),
    .s        (s),
    .r        (r),
    .busy     (busy),
    .conflict (conflict)
  );

  always #5 clk = ~clk;

  // Reference sr_ff driven by the generator outputs.
  always_ff @(posedge clk) begin
    if (s) ff_q <= 1'b1;
    else if (r) ff_q <= 1'b0;
  end

  always @(negedge clk) begin
    if (s) s_cycles = s_cycles + 1;
  end

  always @(s or r) begin
    if (s && r) overlap_seen = 1'b1;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_outs(input string tag, input logic es, input logic er,
                            input logic eb, input logic ec);
    check_output({tag, ".s"}, s, es);
    check_output({tag, ".r"}, r, er);
    check_output({tag, ".busy"}, busy, eb);
    check_output({tag, ".conflict"}, conflict, ec);
  endtask

  initial begin
    // Scenario 1: reset held while buttons toggle, then quiet release.
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_btn = i[0];
      rst_btn = ~i[0];
      step();
    end
    check_outs("s1_in_reset", 0, 0, 0, 0);
    set_btn = 1'b0;
    rst_btn = 1'b0;
    step();
    rst_n = 1'b1;
    step(10);
    check_outs("s1_after_release", 0, 0, 0, 0);

    // Scenario 2: clean set press.
    set_btn = 1'b1;
    step(6);
    check_outs("s2_e6", 0, 0, 0, 0);
    step();
    check_outs("s2_e7", 1, 0, 1, 0);
    step();
    check_outs("s2_e8", 1, 0, 1, 0);
    step();
    check_outs("s2_e9", 0, 0, 1, 0);
    step();
    check_outs("s2_e10", 0, 0, 0, 0);
    check_output("s2_ff_q", ff_q, 1'b1);
    set_btn = 1'b0;
    step(10);

    // Scenario 3: bounce then stable high gives exactly one pulse.
    s_cycles = 0;
    set_btn = 1'b1; step();
    set_btn = 1'b0; step();
    set_btn = 1'b1; step();
    set_btn = 1'b0; step();
    set_btn = 1'b1;
    step(6);
    check_output("s3_e6.s", s, 1'b0);
    step();
    check_output("s3_e7.s", s, 1'b1);
    step(10);
    check_output("s3_s_cycles", s_cycles, 32'd2);
    check_outs("s3_settled", 0, 0, 0, 0);
    set_btn = 1'b0;
    step(10);

    // Scenario 4: simultaneous requests are discarded with a conflict pulse.
    set_btn = 1'b1;
    rst_btn = 1'b1;
    step(6);
    check_outs("s4_e6", 0, 0, 0, 0);
    step();
    check_outs("s4_e7", 0, 0, 0, 1);
    step();
    check_outs("s4_e8", 0, 0, 0, 0);
    step(6);
    check_outs("s4_e14", 0, 0, 0, 0);
    set_btn = 1'b0;
    rst_btn = 1'b0;
    step(10);

    // Scenario 5: reset request arrives during the s pulse and is queued.
    set_btn = 1'b1;
    step(2);
    rst_btn = 1'b1;
    step(5);
    check_outs("s5_e7", 1, 0, 1, 0);
    step();
    check_outs("s5_e8", 1, 0, 1, 0);
    step();
    check_outs("s5_e9", 0, 0, 1, 0);
    step();
    check_outs("s5_e10", 0, 0, 0, 0);
    step();
    check_outs("s5_e11", 0, 1, 1, 0);
    step();
    check_outs("s5_e12", 0, 1, 1, 0);
    step();
    check_outs("s5_e13", 0, 0, 1, 0);
    check_output("s5_ff_q", ff_q, 1'b0);
    step();
    check_outs("s5_e14", 0, 0, 0, 0);
    set_btn = 1'b0;
    rst_btn = 1'b0;
    step(10);

    // Scenario 6: asynchronous reset mid-pulse, then press held through reset.
    set_btn = 1'b1;
    step(7);
    check_output("s6_pre.s", s, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_output("s6_async.s", s, 1'b0);
    check_output("s6_async.busy", busy, 1'b0);
    set_btn = 1'b0;
    step(2);
    rst_n = 1'b1;
    s_cycles = 0;
    step(12);
    check_output("s6_quiet_s_cycles", s_cycles, 32'd0);
    check_outs("s6_quiet", 0, 0, 0, 0);
    set_btn = 1'b1;
    step(12);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(6);
    check_output("s6_held_e6.s", s, 1'b0);
    step();
    check_output("s6_held_e7.s", s, 1'b1);
    check_output("s6_held_e7.busy", busy, 1'b1);
    set_btn = 1'b0;
    step(10);

    check_output("never_s_and_r", overlap_seen, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
